// File: rtl/uart_rx_deser_if.sv
// ----------------------------------------------------------------
// uart_rx_deser_if: received-byte handshake and error-pulse bundle
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface uart_rx_deser_if;
  logic [7:0] d_rx;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output d_rx,
    output valid,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  d_rx,
    input  valid,
    input  frame_err,
    input  overrun,
    output ready
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_deser.sv
// ----------------------------------------------------------------
// uart_rx_deser: 8N1 UART receiver, mid-bit sampling, 1-entry holding register
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd,
  uart_rx_deser_if.master rx_if
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   c_half_m1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   c_last    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic [1:0]    r_sync;
  logic          w_rxd_s;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shreg, w_shreg_nxt;
  logic          w_deliver;
  logic          w_ferr;

  logic [7:0]    r_d_rx;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_overrun;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rxd};
    end
  end

  assign w_rxd_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rxd_s) begin
          w_state_nxt = START;
        end
      end

      START: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_half_m1) begin
          w_cnt_nxt = '0;
          if (!w_rxd_s) begin
            w_bit_nxt   = 3'd0;
            w_state_nxt = DATA;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      DATA: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {w_rxd_s, r_shreg[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end
        end
      end

      STOP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          w_cnt_nxt = '0;
          if (w_rxd_s) begin
            w_deliver   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end
      end

      WAIT_HIGH: begin
        if (w_rxd_s) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // A new byte may replace the held one only if the consumer takes the old one that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_rx      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_deliver & r_valid & ~rx_if.ready;
      if (w_deliver && (!r_valid || rx_if.ready)) begin
        r_d_rx  <= r_shreg;
        r_valid <= 1'b1;
      end else if (r_valid && rx_if.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.d_rx      = r_d_rx;
  assign rx_if.valid     = r_valid;
  assign rx_if.frame_err = r_frame_err;
  assign rx_if.overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
// ----------------------------------------------------------------
// tb_uart_rx_deser: directed frames with a queue-based output scoreboard
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_deser;

  localparam int N = 16;
  // Drive-to-valid: 2 sync cycles, then H + 9N + 1 from first low rxd_s.
  localparam int LAT = 2 + 8 + 9 * 16 + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst;
  logic rxd;

  uart_rx_deser_if bus ();

  uart_rx_deser #(.CLKS_PER_BIT(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rx_if (bus)
  );

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   valid_cycles = 0;
  int   ferr_cnt = 0;
  int   ovr_cnt = 0;
  int   last_ferr_cyc = -1;
  int   last_ovr_cyc = -1;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // A new byte is on offer whenever valid is high and the previous cycle did not hold an unaccepted byte.
  always @(negedge clk) begin
    if (bus.valid && !(prev_valid && !prev_ready)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("byte_data", int'(bus.d_rx), int'(e.data));
        check("byte_cycle", cyc, e.cyc);
      end
    end
    if (bus.valid) valid_cycles++;
    if (bus.frame_err) begin
      ferr_cnt++;
      last_ferr_cyc = cyc;
    end
    if (bus.overrun) begin
      ovr_cnt++;
      last_ovr_cyc = cyc;
    end
    prev_valid = bus.valid;
    prev_ready = bus.ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input bit expect_ok, output int start);
    exp_t e;
    start = cyc;
    if (expect_ok) begin
      e.data = b;
      e.cyc  = cyc + LAT;
      exp_q.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  initial begin : stim
    int s, s2, vc0, fe0, ov0;
    rst       = 1'b1;
    rxd       = 1'b1;
    bus.ready = 1'b1;
    idle(3);
    check("reset_d_rx", int'(bus.d_rx), 0);
    check("reset_valid", int'(bus.valid), 0);
    check("reset_frame_err", int'(bus.frame_err), 0);
    check("reset_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    idle(10);

    // Single frame with the consumer always ready
    vc0 = valid_cycles; fe0 = ferr_cnt; ov0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, s);
    idle(10);
    check("single_valid_one_cycle", valid_cycles - vc0, 1);
    check("single_valid_low", int'(bus.valid), 0);
    check("single_d_rx_held", int'(bus.d_rx), 8'hA5);
    check("single_no_ferr", ferr_cnt - fe0, 0);
    check("single_no_ovr", ovr_cnt - ov0, 0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b1, s);
    send_frame(8'hFF, 1'b1, 1'b1, s);
    idle(10);
    check("b2b_all_received", exp_q.size(), 0);

    // Short low glitch in idle
    vc0 = valid_cycles; fe0 = ferr_cnt;
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(30);
    check("glitch_no_valid", valid_cycles - vc0, 0);
    check("glitch_no_ferr", ferr_cnt - fe0, 0);
    send_frame(8'h3C, 1'b1, 1'b1, s);
    idle(10);

    // Framing error followed by a held-low line
    vc0 = valid_cycles; fe0 = ferr_cnt;
    send_frame(8'h81, 1'b0, 1'b0, s);
    idle(50);
    rxd = 1'b1;
    idle(20);
    check("ferr_one_pulse", ferr_cnt - fe0, 1);
    check("ferr_cycle", last_ferr_cyc, s + LAT);
    check("ferr_no_valid", valid_cycles - vc0, 0);
    send_frame(8'h55, 1'b1, 1'b1, s);
    idle(10);

    // Overrun with the consumer stalled
    bus.ready = 1'b0;
    ov0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b1, s);
    send_frame(8'h22, 1'b1, 1'b0, s2);
    idle(10);
    check("ovr_one_pulse", ovr_cnt - ov0, 1);
    check("ovr_cycle", last_ovr_cyc, s2 + LAT);
    check("ovr_d_rx_kept", int'(bus.d_rx), 8'h11);
    check("ovr_valid_kept", int'(bus.valid), 1);

    // Ready raised only on the stop-sample cycle of the next frame
    ov0 = ovr_cnt;
    s = cyc;
    fork
      send_frame(8'h33, 1'b1, 1'b1, s2);
      begin
        wait_until(s + LAT - 1);
        bus.ready = 1'b1;
        idle(1);
        bus.ready = 1'b0;
      end
    join
    idle(10);
    check("drain_no_ovr", ovr_cnt - ov0, 0);
    check("drain_d_rx", int'(bus.d_rx), 8'h33);
    check("drain_valid", int'(bus.valid), 1);

    // Reset pulse during data bit 4 of 0xF0
    vc0 = valid_cycles; fe0 = ferr_cnt; ov0 = ovr_cnt;
    s = cyc;
    fork
      send_frame(8'hF0, 1'b1, 1'b0, s2);
      begin
        wait_until(s + 88);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_d_rx", int'(bus.d_rx), 0);
        check("midrst_valid", int'(bus.valid), 0);
        check("midrst_frame_err", int'(bus.frame_err), 0);
        check("midrst_overrun", int'(bus.overrun), 0);
      end
    join
    idle(10);
    check("midrst_no_ferr", ferr_cnt - fe0, 0);
    check("midrst_no_ovr", ovr_cnt - ov0, 0);
    check("midrst_valid_low", int'(bus.valid), 0);

    bus.ready = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b1, s);
    idle(10);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
